// File: rtl/esp_cmd_port.sv
// esp_cmd_port -- Z80 host-side I/O register block for the ESP32 command channel.
//
// The Z80 sees two I/O ports:
//   STATUS_ADDR (read)  : bit0 = RX not empty, bit1 = TX full,
//                         bit2 = sticky TX overflow, bit3 = sticky RX underflow
//                         (bits 3:2 read 0 unless ESP_CMD_PORT_ERRFLAGS_EN is defined)
//   STATUS_ADDR (write) : bit7 = flush RX FIFO and mark next data byte as
//                         start-of-message; bit6 = clear error flags (flag build only)
//   DATA_ADDR   (read)  : RX head byte (00h when empty); io_rd pops it
//   DATA_ADDR   (write) : push {pending_som, byte} into the TX FIFO (dropped when full)
//
// Optional feature macro: ESP_CMD_PORT_ERRFLAGS_EN (sticky error flags).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   io_addr, io_wrdata      Z80 I/O address (low byte) and write data
//   io_wr, io_rd            single-cycle access strobes, qualified by io_addr
//   io_rddata               combinational read data of the addressed register
//   tx_data/valid/ready     9-bit byte stream towards the ESP (bit8 = start-of-message)
//   rx_data/valid/ready     8-bit byte stream from the ESP

module esp_cmd_port #(
    parameter logic [7:0]  STATUS_ADDR = 8'hF4,
    parameter logic [7:0]  DATA_ADDR   = 8'hF5,
    parameter int unsigned DEPTH_LOG2  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wrdata,
    input  logic       io_wr,
    input  logic       io_rd,
    output logic [7:0] io_rddata,
    output logic [8:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [8:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic pending_som_q, pending_som_d;

    ptr_t tx_count, rx_count;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic sel_status, sel_data;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_flush;
    logic tx_ovf_flag, rx_udf_flag;
    logic [7:0] status_byte;

    assign sel_status = (io_addr == STATUS_ADDR);
    assign sel_data   = (io_addr == DATA_ADDR);

    // Pointers carry one extra wrap bit, so the difference spans 0..DEPTH.
    assign tx_count = tx_wptr_q - tx_rptr_q;
    assign rx_count = rx_wptr_q - rx_rptr_q;
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == ptr_t'(DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == ptr_t'(DEPTH));

    assign rx_flush = io_wr && sel_status && io_wrdata[7];

    // Full is sampled before the edge, so a same-cycle link pop never rescues a write.
    assign tx_push  = io_wr && sel_data && !tx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = io_rd && sel_data && !rx_empty && !rx_flush;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : tx_mem_q[tx_rptr_q[DEPTH_LOG2-1:0]];
    assign rx_ready = !rx_full && !rx_flush;

    always_comb begin
        tx_wptr_d     = tx_wptr_q + ptr_t'(tx_push);
        tx_rptr_d     = tx_rptr_q + ptr_t'(tx_pop);
        rx_wptr_d     = rx_wptr_q + ptr_t'(rx_push);
        // Flush discards everything by catching the read pointer up; no push can
        // land this cycle because rx_ready is held low during a flush.
        rx_rptr_d     = rx_flush ? rx_wptr_q : (rx_rptr_q + ptr_t'(rx_pop));
        pending_som_d = pending_som_q;
        if (rx_flush) begin
            pending_som_d = 1'b1;
        end else if (tx_push) begin
            pending_som_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            pending_som_q <= 1'b0;
        end else begin
            tx_wptr_q     <= tx_wptr_d;
            tx_rptr_q     <= tx_rptr_d;
            rx_wptr_q     <= rx_wptr_d;
            rx_rptr_q     <= rx_rptr_d;
            pending_som_q <= pending_som_d;
        end
    end

    // Storage arrays need no reset: outputs are gated by the empty flags.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q[DEPTH_LOG2-1:0]] <= {pending_som_q, io_wrdata};
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

`ifdef ESP_CMD_PORT_ERRFLAGS_EN
    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic flag_clr, tx_drop, rx_udf_set;

    assign flag_clr   = io_wr && sel_status && io_wrdata[6];
    assign tx_drop    = io_wr && sel_data && tx_full;
    assign rx_udf_set = io_rd && sel_data && rx_empty;

    // A new error event in the clearing cycle is kept (set beats clear).
    always_comb begin
        tx_ovf_d = flag_clr ? 1'b0 : tx_ovf_q;
        rx_udf_d = flag_clr ? 1'b0 : rx_udf_q;
        if (tx_drop) begin
            tx_ovf_d = 1'b1;
        end
        if (rx_udf_set) begin
            rx_udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    assign tx_ovf_flag = tx_ovf_q;
    assign rx_udf_flag = rx_udf_q;
`else
    assign tx_ovf_flag = 1'b0;
    assign rx_udf_flag = 1'b0;
`endif

    assign status_byte = {4'b0000, rx_udf_flag, tx_ovf_flag, tx_full, !rx_empty};

    always_comb begin
        io_rddata = '0;
        if (sel_status) begin
            io_rddata = status_byte;
        end else if (sel_data && !rx_empty) begin
            io_rddata = rx_mem_q[rx_rptr_q[DEPTH_LOG2-1:0]];
        end
    end

endmodule

// File: tb/tb_esp_cmd_port.sv
module tb_esp_cmd_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] io_addr;
    logic [7:0] io_wrdata;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_rddata;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    always #5 clk = ~clk;

    esp_cmd_port #(
        .STATUS_ADDR(8'hF4),
        .DATA_ADDR  (8'hF5),
        .DEPTH_LOG2 (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .io_addr  (io_addr),
        .io_wrdata(io_wrdata),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_rddata(io_rddata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

`ifdef ESP_CMD_PORT_ERRFLAGS_EN
    localparam logic [7:0] OVF = 8'h04;
    localparam logic [7:0] UDF = 8'h08;
`else
    localparam logic [7:0] OVF = 8'h00;
    localparam logic [7:0] UDF = 8'h00;
`endif

    int errors = 0;
    int checks = 0;

    logic [8:0] tx_q[$];
    logic [7:0] rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every TX handshake and every io_rd access against the scoreboard.
    always @(negedge clk) begin
        logic [8:0] te;
        logic [7:0] re;
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h, expected no transfer", tx_data);
                end else begin
                    te = tx_q.pop_front();
                    chk("tx_stream", 32'(tx_data), 32'(te));
                end
            end
            if (io_rd) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h, expected no read", io_rddata);
                end else begin
                    re = rd_q.pop_front();
                    chk("io_read", 32'(io_rddata), 32'(re));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_addr   = a;
        io_wrdata = d;
        io_wr     = 1'b1;
        tick();
        io_wr     = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        io_addr = a;
        io_rd   = 1'b1;
        rd_q.push_back(exp);
        tick();
        io_rd   = 1'b0;
    endtask

    task automatic rxpush(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        int n;
        n = 0;
        while (tx_valid && n < 40) begin
            tick();
            n++;
        end
        chk("tx_drained", 32'(tx_valid), 32'd0);
        chk("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        io_addr   = 8'hF4;
        io_wrdata = 8'h00;
        io_wr     = 1'b0;
        io_rd     = 1'b0;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        #1;
        chk("rst_status", 32'(io_rddata), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_data", 32'(tx_data), 32'h000);
        io_addr = 8'hF5;
        #1;
        chk("rst_data", 32'(io_rddata), 32'h00);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Start-of-message framing and one-cycle write latency.
        tx_ready = 1'b1;
        wr(8'hF4, 8'h80);
        tx_q.push_back(9'h110);
        wr(8'hF5, 8'h10);
        chk("som_valid_lat", 32'(tx_valid), 32'd1);
        chk("som_data", 32'(tx_data), 32'h110);
        tx_q.push_back(9'h041);
        wr(8'hF5, 8'h41);
        chk("byte2_valid_lat", 32'(tx_valid), 32'd1);
        chk("byte2_data", 32'(tx_data), 32'h041);
        tick();
        chk("tx_idle", 32'(tx_valid), 32'd0);

        // TX fill with the link stalled; the 9th byte is dropped.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back({1'b0, 8'(8'hA0 + i)});
            wr(8'hF5, 8'(8'hA0 + i));
            if (i == 7) rd(8'hF4, 8'h02);
        end
        rd(8'hF4, 8'h02 | OVF);
        chk("tx_stall_hold", 32'(tx_data), 32'h0A0);
        tx_ready = 1'b1;
        tick();
        rd(8'hF4, 8'h00 | OVF);
        drain_tx();
        wr(8'hF4, 8'h40);

        // RX path, in-order reads, empty read leaves pointers alone.
        rxpush(8'h00);
        io_addr = 8'hF4;
        #1;
        chk("rx_status_lat", 32'(io_rddata), 32'h01);
        rxpush(8'h2A);
        rxpush(8'h55);
        rd(8'hF4, 8'h01);
        rd(8'hF5, 8'h00);
        rd(8'hF5, 8'h2A);
        rd(8'hF5, 8'h55);
        rd(8'hF4, 8'h00);
        rd(8'hF5, 8'h00);
        rd(8'hF4, 8'h00 | UDF);
        wr(8'hF4, 8'h40);
        rxpush(8'h77);
        rd(8'hF5, 8'h77);
        rd(8'hF4, 8'h00);

        // RX fill, then refuse an extra byte.
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(8'hB0 + i);
            tick();
        end
        rx_valid = 1'b0;
        chk("rx_full_ready", 32'(rx_ready), 32'd0);
        rxpush(8'hEE);
        rd(8'hF5, 8'hB0);
        chk("rx_ready_after_pop", 32'(rx_ready), 32'd1);

        // Flush colliding with an incoming byte and a read strobe.
        io_addr   = 8'hF4;
        io_wrdata = 8'h80;
        io_wr     = 1'b1;
        io_rd     = 1'b1;
        rx_data   = 8'hCC;
        rx_valid  = 1'b1;
        rd_q.push_back(8'h01);
        #1;
        chk("flush_blocks_rx", 32'(rx_ready), 32'd0);
        tick();
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        rx_valid = 1'b0;
        rd(8'hF4, 8'h00);
        chk("rx_ready_after_flush", 32'(rx_ready), 32'd1);
        tx_q.push_back(9'h133);
        wr(8'hF5, 8'h33);
        repeat (2) tick();
        chk("tx_after_flush_idle", 32'(tx_valid), 32'd0);

`ifdef ESP_CMD_PORT_ERRFLAGS_EN
        // Both sticky flags together, then the clear.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back({1'b0, 8'(8'hC0 + i)});
            wr(8'hF5, 8'(8'hC0 + i));
        end
        rd(8'hF5, 8'h00);
        rd(8'hF4, 8'h0E);
        wr(8'hF4, 8'h40);
        rd(8'hF4, 8'h02);
        tx_ready = 1'b1;
        drain_tx();
`endif

        // Asynchronous reset in the middle of activity.
        tx_ready = 1'b0;
        wr(8'hF4, 8'h80);
        wr(8'hF5, 8'h55);
        rxpush(8'h66);
        chk("pre_reset_valid", 32'(tx_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        io_addr = 8'hF4;
        #1;
        chk("async_tx_valid", 32'(tx_valid), 32'd0);
        chk("async_tx_data", 32'(tx_data), 32'h000);
        chk("async_rx_ready", 32'(rx_ready), 32'd1);
        chk("async_status", 32'(io_rddata), 32'h00);
        io_addr = 8'hF5;
        #1;
        chk("async_data", 32'(io_rddata), 32'h00);
        tick();
        reset_n  = 1'b1;
        tick();
        tx_ready = 1'b1;
        tx_q.push_back(9'h012);
        wr(8'hF5, 8'h12);
        repeat (2) tick();

        chk("final_tx_queue", 32'(tx_q.size()), 32'd0);
        chk("final_rd_queue", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
